// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_controller_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } fetch_state_e;

    localparam logic [31:0] TRAP_VEC_DEFAULT     = 32'h0000_0100;
    localparam int unsigned IMEM_TIMEOUT_DEFAULT = 16;
    localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive cycles spent waiting on the instruction memory and
// flags the cycle in which the wait budget is used up.
module fetch_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(LIMIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q, count_d;

    // Saturating count so a wait extended by a redirect keeps expiring.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: requests the word at the current PC, holds
// it for decode, and steers PC loads for sequential flow, redirects, traps
// and memory timeouts.
//
// state | meaning
// BOOT  | first cycle after reset, no request
// REQ   | fetch request driven at curr_pc_i, waiting for grant
// WAIT  | granted, waiting for rvalid (kill set: response will be dropped)
// HOLD  | instruction presented to decode until accepted
// HALT  | fetch stopped until halt_i drops or a redirect/trap arrives
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC     = TRAP_VEC_DEFAULT,
    parameter int unsigned IMEM_TIMEOUT = IMEM_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [31:0] curr_pc_i,
    output logic        pc_en_o,
    output logic [31:0] next_pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        trap_i,
    input  logic        halt_i,
    output logic        misalign_o,
    output logic        bus_err_o
);

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         tmo_expire;

    logic         flush;
    logic         flush_mis;
    logic [31:0]  flush_pc;

    // Trap beats redirect; a misaligned redirect degrades into a trap.
    assign flush     = trap_i || redirect_i;
    assign flush_mis = !trap_i && redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign flush_pc  = (trap_i || flush_mis) ? TRAP_VEC : redirect_pc_i;

    fetch_timeout_counter #(
        .LIMIT (IMEM_TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .clear_i  (state_q != ST_WAIT),
        .enable_i (state_q == ST_WAIT),
        .expire_o (tmo_expire)
    );

    // Next-state and Mealy outputs; flushes win over everything except BOOT.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_en_o    = 1'b0;
        next_pc_o  = curr_pc_i + INSTR_BYTES;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        imem_req_o = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                imem_req_o = 1'b1;
                if (flush) begin
                    pc_en_o    = 1'b1;
                    next_pc_o  = flush_pc;
                    misalign_o = flush_mis;
                    // A grant in the flush cycle still yields a response; drop it.
                    if (imem_gnt_i) begin
                        state_d = ST_WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (imem_gnt_i) begin
                    state_d = ST_WAIT;
                    kill_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    pc_en_o    = 1'b1;
                    next_pc_o  = flush_pc;
                    misalign_o = flush_mis;
                    if (imem_rvalid_i) begin
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    kill_d = 1'b0;
                    if (kill_q) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_HOLD;
                        instr_d    = imem_rdata_i;
                        instr_pc_d = curr_pc_i;
                    end
                end else if (tmo_expire) begin
                    bus_err_o = 1'b1;
                    pc_en_o   = 1'b1;
                    next_pc_o = TRAP_VEC;
                    kill_d    = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_en_o    = 1'b1;
                    next_pc_o  = flush_pc;
                    misalign_o = flush_mis;
                    state_d    = ST_REQ;
                end else if (instr_ready_i) begin
                    pc_en_o = 1'b1;
                    state_d = halt_i ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: begin
                if (flush) begin
                    pc_en_o    = 1'b1;
                    next_pc_o  = flush_pc;
                    misalign_o = flush_mis;
                    state_d    = ST_REQ;
                end else if (!halt_i) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, kill flag and held instruction registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            kill_q     <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_addr_o   = curr_pc_i;
    assign instr_valid_o = (state_q == ST_HOLD);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios followed by randomized
// traffic checked through a scoreboard against a transaction-level model.
module tb_fetch_controller;

    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [31:0] curr_pc_i;
    logic        pc_en_o;
    logic [31:0] next_pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic        halt_i;
    logic        misalign_o;
    logic        bus_err_o;

    fetch_controller #(
        .TRAP_VEC     (TRAP),
        .IMEM_TIMEOUT (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .curr_pc_i     (curr_pc_i),
        .pc_en_o       (pc_en_o),
        .next_pc_o     (next_pc_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .trap_i        (trap_i),
        .halt_i        (halt_i),
        .misalign_o    (misalign_o),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Program counter register owned by the surrounding core.
    logic [31:0] pc_env;
    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) pc_env <= 32'h0;
        else if (pc_en_o) pc_env <= next_pc_o;
    end
    assign curr_pc_i = pc_env;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic idle();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        trap_i        = 1'b0;
        halt_i        = 1'b0;
    endtask

    // Scoreboard records
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          k;
    } exp_instr_t;

    typedef struct {
        logic        trap;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] cpc;
        int          k;
    } cyc_t;

    exp_instr_t iq[$];
    cyc_t       pq[$];
    bit         mon_en = 1'b0;
    int         n_present = 0;

    cyc_t        m_c;
    exp_instr_t  m_e;
    logic        m_exp_en, m_exp_mis, m_newv, m_due;
    logic [31:0] m_exp_pc;
    logic        prev_v = 1'b0;
    logic [31:0] prev_i, prev_ipc;

    // Monitor: compares DUT outputs to the model's expectations each cycle.
    always begin
        @(negedge clk_i);
        #2;
        if (mon_en && pq.size() > 0) begin
            m_c       = pq.pop_front();
            m_exp_en  = m_c.trap || m_c.redir || (instr_valid_o && m_c.ready);
            m_exp_mis = !m_c.trap && m_c.redir && (m_c.rpc[1:0] != 2'b00);
            if (m_c.trap) m_exp_pc = TRAP;
            else if (m_c.redir) m_exp_pc = (m_c.rpc[1:0] == 2'b00) ? m_c.rpc : TRAP;
            else m_exp_pc = m_c.cpc + 32'd4;
            chk1("pc_en", pc_en_o, m_exp_en);
            if (m_exp_en) chk("next_pc", next_pc_o, m_exp_pc);
            chk1("misalign", misalign_o, m_exp_mis);
            chk1("bus_err", bus_err_o, 1'b0);
            if (imem_req_o) chk("imem_addr", imem_addr_o, m_c.cpc);

            m_newv = instr_valid_o && !prev_v;
            m_due  = (iq.size() > 0) && (iq[0].k + 1 == m_c.k);
            if (m_newv || m_due) begin
                chk1("instr_present", m_newv, m_due);
                if (m_due) begin
                    m_e = iq.pop_front();
                    if (m_newv) begin
                        chk("instr", instr_o, m_e.instr);
                        chk("instr_pc", instr_pc_o, m_e.pc);
                        n_present++;
                    end
                end
            end
            if (instr_valid_o && prev_v) begin
                chk("hold_instr", instr_o, prev_i);
                chk("hold_pc", instr_pc_o, prev_ipc);
            end
            prev_v   = instr_valid_o;
            prev_i   = instr_o;
            prev_ipc = instr_pc_o;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Memory model state for the random phase
    bit          outst;
    bit          ostale;
    logic [31:0] oaddr;
    int          lat;
    bit          flush, rv, quiet;
    logic [31:0] rpc;

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        chk1("rst_valid", instr_valid_o, 1'b0);
        chk1("rst_req", imem_req_o, 1'b0);
        chk1("rst_pc_en", pc_en_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_instr_pc", instr_pc_o, 32'h0);
        chk1("rst_misalign", misalign_o, 1'b0);
        chk1("rst_bus_err", bus_err_o, 1'b0);

        // Basic fetch: BOOT, REQ+gnt, WAIT+rvalid, HOLD accepted on cycle 4
        @(negedge clk_i); rst_n = 1'b1; #1;
        chk1("boot_req", imem_req_o, 1'b0);
        @(negedge clk_i); imem_gnt_i = 1'b1; #1;
        chk1("c2_req", imem_req_o, 1'b1);
        chk("c2_addr", imem_addr_o, 32'h0);
        @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hCAFE_0001; instr_ready_i = 1'b1; #1;
        chk1("c3_valid", instr_valid_o, 1'b0);
        chk1("c3_pc_en", pc_en_o, 1'b0);
        @(negedge clk_i); imem_rvalid_i = 1'b0; #1;
        chk1("c4_valid", instr_valid_o, 1'b1);
        chk("c4_instr", instr_o, 32'hCAFE_0001);
        chk("c4_instr_pc", instr_pc_o, 32'h0);
        chk1("c4_pc_en", pc_en_o, 1'b1);
        chk("c4_next_pc", next_pc_o, 32'h4);

        // Decode stalls for 5 cycles
        @(negedge clk_i); instr_ready_i = 1'b0; imem_gnt_i = 1'b1; #1;
        chk("stall_addr", imem_addr_o, 32'h4);
        @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hCAFE_0002;
        @(negedge clk_i); imem_rvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            chk1("stall_valid", instr_valid_o, 1'b1);
            chk("stall_instr", instr_o, 32'hCAFE_0002);
            chk("stall_instr_pc", instr_pc_o, 32'h4);
            chk1("stall_pc_en", pc_en_o, 1'b0);
        end
        @(negedge clk_i); instr_ready_i = 1'b1; #1;
        chk1("stall_accept_en", pc_en_o, 1'b1);
        chk("stall_accept_pc", next_pc_o, 32'h8);

        // Redirect during WAIT drops the late response
        @(negedge clk_i); instr_ready_i = 1'b0; imem_gnt_i = 1'b1; #1;
        chk("redir_req_addr", imem_addr_o, 32'h8);
        @(negedge clk_i); imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40; #1;
        chk1("redir_pc_en", pc_en_o, 1'b1);
        chk("redir_next_pc", next_pc_o, 32'h40);
        chk1("redir_misalign", misalign_o, 1'b0);
        @(negedge clk_i); redirect_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; #1;
        chk1("redir_still_wait", imem_req_o, 1'b0);
        chk1("redir_late_pc_en", pc_en_o, 1'b0);
        @(negedge clk_i); imem_rvalid_i = 1'b0; instr_ready_i = 1'b1; #1;
        chk1("redir_dropped", instr_valid_o, 1'b0);
        chk1("redir_new_req", imem_req_o, 1'b1);
        chk("redir_new_addr", imem_addr_o, 32'h40);

        // Misaligned redirect
        @(negedge clk_i); instr_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h42; #1;
        chk1("mis_pulse", misalign_o, 1'b1);
        chk1("mis_pc_en", pc_en_o, 1'b1);
        chk("mis_next_pc", next_pc_o, TRAP);
        @(negedge clk_i); redirect_i = 1'b0; #1;
        chk1("mis_one_cycle", misalign_o, 1'b0);
        chk("mis_addr", imem_addr_o, TRAP);

        // Trap and redirect together
        @(negedge clk_i); trap_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h80; #1;
        chk1("tr_pc_en", pc_en_o, 1'b1);
        chk("tr_next_pc", next_pc_o, TRAP);
        chk1("tr_misalign", misalign_o, 1'b0);
        @(negedge clk_i); trap_i = 1'b0; redirect_i = 1'b0; #1;
        chk("tr_addr", imem_addr_o, TRAP);

        // Memory never answers: bus error on the 16th WAIT cycle
        @(negedge clk_i); imem_gnt_i = 1'b1; #1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk_i); imem_gnt_i = 1'b0; #1;
            chk1("to_bus_err", bus_err_o, logic'(i == 16));
            chk1("to_pc_en", pc_en_o, logic'(i == 16));
        end
        chk("to_next_pc", next_pc_o, TRAP);
        @(negedge clk_i); #1;
        chk1("to_bus_err_clear", bus_err_o, 1'b0);
        chk1("to_back_to_req", imem_req_o, 1'b1);

        // PC wrap at the top of the address space
        @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; #1;
        @(negedge clk_i); redirect_i = 1'b0; imem_gnt_i = 1'b1; #1;
        chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
        @(negedge clk_i); imem_rvalid_i = 1'b0; instr_ready_i = 1'b1; #1;
        chk("wrap_instr_pc", instr_pc_o, 32'hFFFF_FFFC);
        chk1("wrap_pc_en", pc_en_o, 1'b1);
        chk("wrap_next_pc", next_pc_o, 32'h0);

        // Halt deferred to acceptance, then released
        @(negedge clk_i); instr_ready_i = 1'b0; halt_i = 1'b1; imem_gnt_i = 1'b1; #1;
        chk1("halt_deferred_req", imem_req_o, 1'b1);
        @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5;
        @(negedge clk_i); imem_rvalid_i = 1'b0; instr_ready_i = 1'b1; #1;
        chk1("halt_accept_en", pc_en_o, 1'b1);
        chk("halt_accept_pc", next_pc_o, 32'h4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); instr_ready_i = 1'b0; #1;
            chk1("halt_no_req", imem_req_o, 1'b0);
            chk1("halt_no_valid", instr_valid_o, 1'b0);
        end
        @(negedge clk_i); halt_i = 1'b0; #1;
        chk1("halt_exit_cycle", imem_req_o, 1'b0);
        @(negedge clk_i); #1;
        chk1("halt_resume_req", imem_req_o, 1'b1);
        chk("halt_resume_addr", imem_addr_o, 32'h4);

        // Reset while waiting; the late response must be ignored
        @(negedge clk_i); imem_gnt_i = 1'b1;
        @(negedge clk_i); imem_gnt_i = 1'b0; rst_n = 1'b0; #1;
        chk1("rstw_req", imem_req_o, 1'b0);
        @(negedge clk_i); rst_n = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0; #1;
        chk1("rstw_boot", imem_req_o, 1'b0);
        @(negedge clk_i); #1;
        chk1("rstw_req_after", imem_req_o, 1'b1);
        chk("rstw_addr", imem_addr_o, 32'h0);
        chk1("rstw_no_valid", instr_valid_o, 1'b0);
        @(negedge clk_i); imem_rvalid_i = 1'b0; #1;
        chk1("rstw_no_valid2", instr_valid_o, 1'b0);

        // Randomized traffic against the scoreboard
        idle();
        rst_n = 1'b0;
        @(negedge clk_i);
        rst_n  = 1'b1;
        outst  = 1'b0;
        prev_v = 1'b0;
        mon_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            quiet = (k >= 2985);
            @(negedge clk_i);
            trap_i        = !quiet && ($urandom_range(0, 99) < 3);
            redirect_i    = !quiet && ($urandom_range(0, 99) < 8);
            rpc           = {16'h0, 16'($urandom)};
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            redirect_pc_i = rpc;
            instr_ready_i = quiet || ($urandom_range(0, 99) < 60);
            halt_i        = !quiet && ($urandom_range(0, 99) < 4);
            imem_gnt_i    = !quiet && ($urandom_range(0, 99) < 60);
            flush         = trap_i || redirect_i;
            rv            = 1'b0;
            // A response is delivered only if no flush touched its lifetime.
            if (outst) begin
                if (lat == 0) begin
                    rv    = 1'b1;
                    outst = 1'b0;
                    if (!(ostale || flush)) iq.push_back('{mem_word(oaddr), oaddr, k});
                end else begin
                    lat--;
                    ostale = ostale || flush;
                end
            end else if (imem_gnt_i && imem_req_o) begin
                outst  = 1'b1;
                oaddr  = curr_pc_i;
                lat    = $urandom_range(0, 3);
                ostale = flush;
            end
            imem_rvalid_i = rv;
            imem_rdata_i  = rv ? mem_word(oaddr) : $urandom;
            pq.push_back('{trap_i, redirect_i, rpc, instr_ready_i, curr_pc_i, k});
        end
        @(negedge clk_i);
        #3;
        mon_en = 1'b0;
        idle();
        chk("iq_drained", iq.size(), 32'd0);
        chk1("progress", logic'(n_present > 50), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter TRAP_VEC, default 32'h0000_0100, trap/misalign target address.
REQ-002 SHALL have parameter IMEM_TIMEOUT, default 16, cycles WAIT may last before bus-error.
REQ-003 SHALL have clk_i  in  1  clock, rising edge.
REQ-004 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have curr_pc_i  in  32  current PC from program counter.
REQ-006 SHALL have pc_en_o  out  1  PC load enable.
REQ-007 SHALL have next_pc_o  out  32  PC load value.
REQ-008 SHALL have imem_req_o  out  1  fetch request; imem_addr_o  out  32  fetch address.
REQ-009 SHALL have imem_gnt_i  in  1  request accepted; imem_rvalid_i  in  1  data valid; imem_rdata_i  in  32  instruction.
REQ-010 SHALL have instr_valid_o  out  1; instr_o  out  32; instr_pc_o  out  32; instr_ready_i  in  1 (decode handshake).
REQ-011 SHALL have redirect_i  in  1, redirect_pc_i  in  32 (branch/jump); trap_i  in  1; halt_i  in  1.
REQ-012 SHALL have misalign_o  out  1 and bus_err_o  out  1, one-cycle pulses.

Function
REQ-013 SHALL implement FSM states BOOT, REQ, WAIT, HOLD, HALT.
REQ-014 BOOT: one cycle after reset release, no request, then REQ.
REQ-015 REQ: imem_req_o=1, imem_addr_o=curr_pc_i; on imem_gnt_i -> WAIT, else stay.
REQ-016 WAIT: on imem_rvalid_i capture rdata and curr_pc_i into instr_o/instr_pc_o, go HOLD; imem_req_o=0.
REQ-017 HOLD: instr_valid_o=1; instr_o/instr_pc_o stable until instr_valid_o&&instr_ready_i.
REQ-018 On acceptance: pc_en_o=1, next_pc_o=curr_pc_i+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), next state REQ (HALT if halt_i).
REQ-019 Zero-bubble path: rvalid with instr_ready_i already high still spends one cycle in HOLD.
REQ-020 Priority, same cycle: trap_i > redirect_i > acceptance; redirect/trap in any state except BOOT SHALL win.
REQ-021 trap_i: pc_en_o=1, next_pc_o=TRAP_VEC, drop HOLD contents, next state REQ.
REQ-022 redirect_i with redirect_pc_i[1:0]==0: pc_en_o=1, next_pc_o=redirect_pc_i, next REQ; else misalign_o=1 and behave as trap.
REQ-023 Redirect/trap in WAIT: set kill flag, stay WAIT; the pending rvalid SHALL be discarded (no instr_valid_o), then REQ.
REQ-024 Timeout: counter counts WAIT cycles; reaching IMEM_TIMEOUT without rvalid pulses bus_err_o, clears kill, loads TRAP_VEC, -> REQ.
REQ-025 HALT: no requests, instr_valid_o=0; leaves to REQ when halt_i=0, or on trap_i/redirect_i.
REQ-026 halt_i in REQ/WAIT SHALL be deferred until HOLD acceptance.
REQ-027 pc_en_o SHALL be 0 in all cases not listed above; at most one PC load per cycle.

Reset
REQ-028 rst_n low: state BOOT, pc_en_o=0, imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, kill=0, timeout count 0, misalign_o=0, bus_err_o=0.
REQ-029 Reset mid-WAIT SHALL abandon the transaction; a late rvalid after release SHALL be ignored (BOOT/REQ ignore rvalid).

Structure
REQ-030 Shared package SHALL hold FSM state enum, TRAP_VEC default, INSTR_BYTES=4.
REQ-031 One sub-module fetch_timeout_counter (clear/enable/expire) is natural; remainder flat.

Verification
REQ-032 Reset release, gnt same cycle, rvalid next, ready=1 -> instr_valid_o on cycle 4, pc_en_o with next_pc_o=32'h4.
REQ-033 ready held 0 for 5 cycles in HOLD -> instr_o/instr_pc_o stable, pc_en_o=0 throughout, single load on accept.
REQ-034 redirect_i to 32'h0000_0040 during WAIT -> late rvalid dropped, next imem_addr_o=32'h40.
REQ-035 redirect_pc_i=32'h0000_0042 -> misalign_o pulse, next_pc_o=TRAP_VEC.
REQ-036 trap_i and redirect_i same cycle -> next_pc_o=TRAP_VEC only.
REQ-037 no rvalid for 16 WAIT cycles -> bus_err_o pulse, next_pc_o=TRAP_VEC; curr_pc_i=32'hFFFF_FFFC accept -> next_pc_o=0.
